keccak_seq_ctrl: RTL and testbench
==================================

KECCAK_SEQ_CTRL -- requirements
Module: keccak_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of index and timeout counters.
REQ-002 SHALL have parameter LOAD_WORDS, default 25: lane words accepted per load phase; legal range 1..2^CNT_W.
REQ-003 SHALL have parameter STORE_WORDS, default 25: lane words written to dmem per store phase; legal range 1..2^CNT_W.
REQ-004 SHALL have parameter TIMEOUT, default 64: maximum WAIT cycles before error; legal range 1..2^CNT_W.
REQ-005 SHALL use a single clock and an asynchronous, active-low reset.
REQ-006 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-007 SHALL have port RST  input  1  asynchronous active-low reset.
REQ-008 SHALL have port keccak_we  input  1  host lane-write strobe.
REQ-009 SHALL have port keccak_ready  input  1  core idle, able to accept start.
REQ-010 SHALL have port keccak_valid  input  1  core result valid.
REQ-011 SHALL have port abort  input  1  synchronous sequence abort.
REQ-012 SHALL have port keccak_we_real  output  1  gated write to core buffer.
REQ-013 SHALL have port load_idx  output  CNT_W  index of next lane word to be loaded.
REQ-014 SHALL have port keccak_start  output  1  one-cycle core start pulse.
REQ-015 SHALL have port keccak_dmem_write  output  1  dmem write enable.
REQ-016 SHALL have port store_idx  output  CNT_W  index of lane word being stored.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port done  output  1  one-cycle completion pulse.
REQ-019 SHALL have port error  output  1  sticky timeout flag.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, START, WAIT, STORE, DONE.
REQ-021 SHALL drive keccak_we_real = keccak_we in IDLE and LOAD, and 0 in all other states.
REQ-022 SHALL increment load_idx on each accepted write (keccak_we_real=1); in LOAD, cycles without keccak_we SHALL NOT advance load_idx.
REQ-023 IDLE: on accepted write, SHALL go to LOAD; if LOAD_WORDS=1, SHALL go directly to START.
REQ-024 LOAD: on the accepted write that makes load_idx reach LOAD_WORDS, SHALL go to START next cycle and clear load_idx to 0.
REQ-025 START: keccak_start = keccak_ready (combinational); when keccak_ready=1, SHALL go to WAIT next cycle, otherwise stay in START indefinitely.
REQ-026 WAIT: timeout counter starts at 0 on entry and increments each cycle.
REQ-027 WAIT: keccak_valid=1 SHALL cause a transition to STORE next cycle.
REQ-028 WAIT: counter == TIMEOUT-1 with keccak_valid=0 SHALL set error and return to IDLE; keccak_valid SHALL win on the same cycle.
REQ-029 STORE: keccak_dmem_write=1 for exactly STORE_WORDS consecutive cycles, with store_idx = 0..STORE_WORDS-1; then SHALL go to DONE.
REQ-030 keccak_dmem_write SHALL be 0 and store_idx SHALL hold 0 outside STORE.
REQ-031 DONE: done=1 for one cycle, then SHALL go to IDLE.
REQ-032 keccak_valid outside WAIT, and keccak_ready outside START, SHALL be ignored.
REQ-033 error SHALL clear on the first accepted write in IDLE and is otherwise sticky.
REQ-034 abort=1 in any state SHALL go to IDLE next cycle and clear load_idx, store_idx and the timeout counter; it SHALL NOT set done or error.
REQ-035 abort SHALL have priority over every other transition; in IDLE, abort SHALL block keccak_we_real.
REQ-036 Counters SHALL never wrap within legal parameter ranges.

Reset
REQ-037 RST=0 SHALL asynchronously force IDLE, load_idx=0, store_idx=0, timeout counter=0, and error=0.
REQ-038 During reset, keccak_start, keccak_dmem_write, busy and done SHALL all be 0.
REQ-039 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse; the first edge after release SHALL sample IDLE.

Verification
REQ-040 Defaults, 25 back-to-back writes, ready=1, valid 10 cycles after start -> one start pulse the cycle after the 25th write; 25 dmem_write cycles with store_idx 0..24; done once; error=0.
REQ-041 25 writes with 1-cycle gaps -> load_idx advances only on write cycles; START is entered only after the 25th write.
REQ-042 ready held 0 for 20 cycles in START -> keccak_start=0 throughout; a single pulse on the first ready=1 cycle.
REQ-043 valid never asserted -> error=1 after exactly 64 WAIT cycles, FSM returns to IDLE, no done; the next accepted write clears error.
REQ-044 abort in STORE at store_idx=7 -> dmem_write=0 next cycle, IDLE, no done; a following full sequence completes normally.
REQ-045 LOAD_WORDS=1, STORE_WORDS=1, TIMEOUT=1 -> single write goes straight to START; valid on the first WAIT cycle gives one store cycle; no valid gives immediate error.

Source files
------------

// File: rtl/keccak_seq_ctrl.sv
// Keccak sequencing controller: gates host lane writes into the core buffer,
// issues the core start pulse, waits for the result with a timeout, then
// streams the result lanes to dmem and pulses done.
module keccak_seq_ctrl #(
  parameter int CNT_W       = 8,
  parameter int LOAD_WORDS  = 25,
  parameter int STORE_WORDS = 25,
  parameter int TIMEOUT     = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             keccak_we,
  input  logic             keccak_ready,
  input  logic             keccak_valid,
  input  logic             abort,
  output logic             keccak_we_real,
  output logic [CNT_W-1:0] load_idx,
  output logic             keccak_start,
  output logic             keccak_dmem_write,
  output logic [CNT_W-1:0] store_idx,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_STORE,
    ST_DONE
  } state_t;

  // Terminal counts are compared against the last index rather than the word
  // count, so a count of 2^CNT_W still fits in CNT_W bits without wrapping.
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_WORDS - 1);
  localparam logic [CNT_W-1:0] STORE_LAST = CNT_W'(STORE_WORDS - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] load_nxt, store_nxt;
  logic [CNT_W-1:0] tcnt, tcnt_nxt;
  logic             error_nxt;

  // State and counter registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      load_idx  <= '0;
      store_idx <= '0;
      tcnt      <= '0;
      error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      load_idx  <= load_nxt;
      store_idx <= store_nxt;
      tcnt      <= tcnt_nxt;
      error     <= error_nxt;
    end
  end

  // Next-state, next-counter and output decode.
  always_comb begin
    state_nxt         = state;
    load_nxt          = load_idx;
    store_nxt         = store_idx;
    tcnt_nxt          = tcnt;
    error_nxt         = error;
    keccak_we_real    = 1'b0;
    keccak_start      = 1'b0;
    keccak_dmem_write = 1'b0;
    done              = 1'b0;
    busy              = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        keccak_we_real = keccak_we & ~abort;
        if (keccak_we_real) begin
          error_nxt = 1'b0;
          // load_idx is 0 here, so LOAD_WORDS=1 goes straight to START.
          if (load_idx == LOAD_LAST) begin
            state_nxt = ST_START;
            load_nxt  = '0;
          end else begin
            state_nxt = ST_LOAD;
            load_nxt  = load_idx + ONE;
          end
        end
      end
      ST_LOAD: begin
        keccak_we_real = keccak_we;
        if (keccak_we_real) begin
          if (load_idx == LOAD_LAST) begin
            state_nxt = ST_START;
            load_nxt  = '0;
          end else begin
            load_nxt = load_idx + ONE;
          end
        end
      end
      ST_START: begin
        keccak_start = keccak_ready;
        if (keccak_ready) begin
          state_nxt = ST_WAIT;
          tcnt_nxt  = '0;
        end
      end
      ST_WAIT: begin
        if (keccak_valid) begin
          state_nxt = ST_STORE;
          tcnt_nxt  = '0;
        end else if (tcnt == TO_LAST) begin
          state_nxt = ST_IDLE;
          error_nxt = 1'b1;
          tcnt_nxt  = '0;
        end else begin
          tcnt_nxt = tcnt + ONE;
        end
      end
      ST_STORE: begin
        keccak_dmem_write = 1'b1;
        if (store_idx == STORE_LAST) begin
          state_nxt = ST_DONE;
          store_nxt = '0;
        end else begin
          store_nxt = store_idx + ONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Abort overrides everything above; error keeps its current value.
    if (abort) begin
      state_nxt = ST_IDLE;
      load_nxt  = '0;
      store_nxt = '0;
      tcnt_nxt  = '0;
      error_nxt = error;
    end
  end

endmodule

// File: tb/tb_keccak_seq_ctrl.sv
// Bench for keccak_seq_ctrl: small-parameter instances driven from vector
// tables, default instance driven by hand-written multi-cycle sequences.
module tb_keccak_seq_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  // Default-parameter instance
  logic       d_we = 0, d_rdy = 0, d_val = 0, d_ab = 0;
  logic       d_wer, d_start, d_dmw, d_busy, d_done, d_err;
  logic [7:0] d_lidx, d_sidx;

  keccak_seq_ctrl dut (
    .CLK(CLK), .RST(RST), .keccak_we(d_we), .keccak_ready(d_rdy),
    .keccak_valid(d_val), .abort(d_ab), .keccak_we_real(d_wer),
    .load_idx(d_lidx), .keccak_start(d_start), .keccak_dmem_write(d_dmw),
    .store_idx(d_sidx), .busy(d_busy), .done(d_done), .error(d_err)
  );

  // Small instance: 3 loads, 2 stores, timeout 4
  logic       s_we = 0, s_rdy = 0, s_val = 0, s_ab = 0;
  logic       s_wer, s_start, s_dmw, s_busy, s_done, s_err;
  logic [3:0] s_lidx, s_sidx;

  keccak_seq_ctrl #(.CNT_W(4), .LOAD_WORDS(3), .STORE_WORDS(2), .TIMEOUT(4)) dut_s (
    .CLK(CLK), .RST(RST), .keccak_we(s_we), .keccak_ready(s_rdy),
    .keccak_valid(s_val), .abort(s_ab), .keccak_we_real(s_wer),
    .load_idx(s_lidx), .keccak_start(s_start), .keccak_dmem_write(s_dmw),
    .store_idx(s_sidx), .busy(s_busy), .done(s_done), .error(s_err)
  );

  // Minimal instance: 1 load, 1 store, timeout 1
  logic       o_we = 0, o_rdy = 0, o_val = 0, o_ab = 0;
  logic       o_wer, o_start, o_dmw, o_busy, o_done, o_err;
  logic [3:0] o_lidx, o_sidx;

  keccak_seq_ctrl #(.CNT_W(4), .LOAD_WORDS(1), .STORE_WORDS(1), .TIMEOUT(1)) dut_1 (
    .CLK(CLK), .RST(RST), .keccak_we(o_we), .keccak_ready(o_rdy),
    .keccak_valid(o_val), .abort(o_ab), .keccak_we_real(o_wer),
    .load_idx(o_lidx), .keccak_start(o_start), .keccak_dmem_write(o_dmw),
    .store_idx(o_sidx), .busy(o_busy), .done(o_done), .error(o_err)
  );

  int d_done_cnt = 0;
  always @(posedge CLK) if (d_done) d_done_cnt++;

  typedef struct {
    logic [3:0] in;   // {we, ready, valid, abort}
    logic       wer;
    logic [7:0] lidx;
    logic       start;
    logic       dmw;
    logic [7:0] sidx;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  vec_t tab_s[$];
  vec_t tab_1[$];

  function automatic vec_t mk(input logic [3:0] i, input logic wer, input logic [7:0] li,
                              input logic st, input logic dm, input logic [7:0] si,
                              input logic bz, input logic dn, input logic er);
    vec_t v;
    v.in = i; v.wer = wer; v.lidx = li; v.start = st; v.dmw = dm;
    v.sidx = si; v.busy = bz; v.done = dn; v.err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input int unsigned inst, input vec_t v, input int unsigned row);
    logic [22:0] act, exp;
    @(negedge CLK);
    if (inst == 0) {s_we, s_rdy, s_val, s_ab} = v.in;
    else           {o_we, o_rdy, o_val, o_ab} = v.in;
    #2;
    if (inst == 0)
      act = {s_wer, 4'b0, s_lidx, s_start, s_dmw, 4'b0, s_sidx, s_busy, s_done, s_err};
    else
      act = {o_wer, 4'b0, o_lidx, o_start, o_dmw, 4'b0, o_sidx, o_busy, o_done, o_err};
    exp = {v.wer, v.lidx, v.start, v.dmw, v.sidx, v.busy, v.done, v.err};
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec inst%0d row%0d: got %06h expected %06h", inst, row, act, exp);
    end
  endtask

  task automatic d_cycle(input logic we, input logic rdy, input logic val, input logic ab);
    @(negedge CLK);
    d_we = we; d_rdy = rdy; d_val = val; d_ab = ab;
    #2;
  endtask

  // One complete sequence on the default instance: 25 writes, start, valid
  // on the 10th WAIT cycle, 25 stores, done.
  task automatic full_seq();
    for (int unsigned i = 0; i < 25; i++) begin
      d_cycle(1, 0, 0, 0);
      chk("fs_wer", d_wer, 1);
      chk("fs_lidx", d_lidx, i);
      chk("fs_start_ld", d_start, 0);
    end
    d_cycle(0, 1, 0, 0);
    chk("fs_start", d_start, 1);
    chk("fs_lidx_clr", d_lidx, 0);
    for (int unsigned k = 0; k < 10; k++) begin
      d_cycle(0, 1, (k == 9), 0);
      chk("fs_wait_start", d_start, 0);
      chk("fs_wait_busy", d_busy, 1);
      chk("fs_wait_dmw", d_dmw, 0);
    end
    for (int unsigned j = 0; j < 25; j++) begin
      d_cycle(0, 0, 0, 0);
      chk("fs_dmw", d_dmw, 1);
      chk("fs_sidx", d_sidx, j);
      chk("fs_done_early", d_done, 0);
    end
    d_cycle(0, 0, 0, 0);
    chk("fs_done", d_done, 1);
    chk("fs_dmw_off", d_dmw, 0);
    chk("fs_sidx_hold", d_sidx, 0);
    d_cycle(0, 0, 0, 0);
    chk("fs_done_once", d_done, 0);
    chk("fs_idle", d_busy, 0);
    chk("fs_err", d_err, 0);
  endtask

  initial begin
    // Small instance table
    tab_s.push_back(mk(4'b1000, 1, 0, 0, 0, 0, 0, 0, 0));
    tab_s.push_back(mk(4'b0000, 0, 1, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b1000, 1, 1, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b1000, 1, 2, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0010, 0, 0, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0100, 0, 0, 1, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0100, 0, 0, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0010, 0, 0, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0000, 0, 0, 0, 1, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0000, 0, 0, 0, 1, 1, 1, 0, 0));
    tab_s.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 1, 0));
    tab_s.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
    tab_s.push_back(mk(4'b1000, 1, 0, 0, 0, 0, 0, 0, 0));
    tab_s.push_back(mk(4'b1000, 1, 1, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b1000, 1, 2, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0100, 0, 0, 1, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 1));
    tab_s.push_back(mk(4'b1001, 0, 0, 0, 0, 0, 0, 0, 1));
    tab_s.push_back(mk(4'b1000, 1, 0, 0, 0, 0, 0, 0, 1));
    tab_s.push_back(mk(4'b0000, 0, 1, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0001, 0, 1, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
    tab_s.push_back(mk(4'b1000, 1, 0, 0, 0, 0, 0, 0, 0));
    tab_s.push_back(mk(4'b1000, 1, 1, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b1000, 1, 2, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0100, 0, 0, 1, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0010, 0, 0, 0, 0, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0000, 0, 0, 0, 1, 0, 1, 0, 0));
    tab_s.push_back(mk(4'b0000, 0, 0, 0, 1, 1, 1, 0, 0));
    tab_s.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 1, 0));
    tab_s.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));

    // Minimal instance table
    tab_1.push_back(mk(4'b1000, 1, 0, 0, 0, 0, 0, 0, 0));
    tab_1.push_back(mk(4'b0100, 0, 0, 1, 0, 0, 1, 0, 0));
    tab_1.push_back(mk(4'b0010, 0, 0, 0, 0, 0, 1, 0, 0));
    tab_1.push_back(mk(4'b0000, 0, 0, 0, 1, 0, 1, 0, 0));
    tab_1.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 1, 0));
    tab_1.push_back(mk(4'b1000, 1, 0, 0, 0, 0, 0, 0, 0));
    tab_1.push_back(mk(4'b0100, 0, 0, 1, 0, 0, 1, 0, 0));
    tab_1.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0));
    tab_1.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 1));
    tab_1.push_back(mk(4'b1000, 1, 0, 0, 0, 0, 0, 0, 1));
    tab_1.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0));
    tab_1.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 1, 0, 0));
    tab_1.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));

    // Outputs while held in reset
    #12;
    chk("rst_d", {d_lidx, d_sidx, d_start, d_dmw, d_busy, d_done, d_err}, 0);
    chk("rst_s", {s_lidx, s_sidx, s_start, s_dmw, s_busy, s_done, s_err}, 0);
    chk("rst_1", {o_lidx, o_sidx, o_start, o_dmw, o_busy, o_done, o_err}, 0);
    @(negedge CLK);
    RST = 1'b1;

    for (int unsigned r = 0; r < tab_s.size(); r++) run_vec(0, tab_s[r], r);
    for (int unsigned r = 0; r < tab_1.size(); r++) run_vec(1, tab_1[r], r);

    // Back-to-back sequence on default instance
    full_seq();

    // Writes with one-cycle gaps
    for (int unsigned i = 0; i < 25; i++) begin
      d_cycle(1, 0, 0, 0);
      chk("gap_wer", d_wer, 1);
      chk("gap_lidx", d_lidx, i);
      if (i < 24) begin
        d_cycle(0, 0, 0, 0);
        chk("gap_hold_lidx", d_lidx, i + 1);
        chk("gap_hold_wer", d_wer, 0);
        chk("gap_no_start", d_start, 0);
      end
    end
    // Ready held low in START
    for (int unsigned c = 0; c < 20; c++) begin
      d_cycle(0, 0, 0, 0);
      chk("rdy0_start", d_start, 0);
      chk("rdy0_busy", d_busy, 1);
      chk("rdy0_lidx", d_lidx, 0);
    end
    d_cycle(0, 1, 0, 0);
    chk("rdy1_start", d_start, 1);
    // Timeout: exactly 64 WAIT cycles with ready still high
    for (int unsigned c = 0; c < 64; c++) begin
      d_cycle(0, 1, 0, 0);
      chk("to_start", d_start, 0);
      chk("to_busy", d_busy, 1);
      chk("to_err_early", d_err, 0);
    end
    d_cycle(0, 0, 0, 0);
    chk("to_idle", d_busy, 0);
    chk("to_err", d_err, 1);
    chk("to_nodone", d_done, 0);
    d_cycle(1, 0, 0, 0);
    chk("clr_wer", d_wer, 1);
    chk("clr_err_still", d_err, 1);
    d_cycle(0, 0, 0, 0);
    chk("clr_err", d_err, 0);
    chk("clr_lidx", d_lidx, 1);
    for (int unsigned i = 1; i < 25; i++) begin
      d_cycle(1, 0, 0, 0);
      chk("ab_lidx", d_lidx, i);
    end
    d_cycle(0, 1, 0, 0);
    chk("ab_start", d_start, 1);
    d_cycle(0, 0, 1, 0);
    chk("ab_wait", d_busy, 1);
    // Abort in STORE at store_idx 7
    for (int unsigned j = 0; j < 8; j++) begin
      d_cycle(0, 0, 0, (j == 7));
      chk("ab_dmw", d_dmw, 1);
      chk("ab_sidx", d_sidx, j);
    end
    d_cycle(0, 0, 0, 0);
    chk("ab_dmw_off", d_dmw, 0);
    chk("ab_idle", d_busy, 0);
    chk("ab_sidx_clr", d_sidx, 0);
    chk("ab_nodone", d_done, 0);
    chk("ab_noerr", d_err, 0);
    full_seq();

    // Reset in the middle of a load
    d_cycle(1, 0, 0, 0);
    d_cycle(1, 0, 0, 0);
    d_cycle(1, 0, 0, 0);
    chk("mr_pre", d_lidx, 2);
    #1 RST = 1'b0;
    #1;
    chk("mr_async", {d_lidx, d_sidx, d_start, d_dmw, d_busy, d_done, d_err}, 0);
    @(negedge CLK);
    d_we = 0;
    RST = 1'b1;
    d_cycle(0, 0, 0, 0);
    chk("mr_idle", d_busy, 0);
    d_cycle(1, 0, 0, 0);
    chk("mr_lidx0", d_lidx, 0);
    d_cycle(0, 0, 0, 0);
    chk("mr_lidx1", d_lidx, 1);
    d_cycle(0, 0, 0, 1);
    d_cycle(0, 0, 0, 0);
    chk("mr_abort_idle", d_busy, 0);

    chk("done_count", d_done_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
